// File: rtl/mfp_pwm_multi_digit_display_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : mfp_pwm_multi_digit_display_pkg
//  Purpose  : Shared types, segment bit positions and the hex-to-segment
//             encode table for the multiplexed seven-segment scanner.
//  Revision : 1.0  initial release
// ============================================================================
package mfp_pwm_multi_digit_display_pkg;

  // Bit positions inside the {g,f,e,d,c,b,a} segment vector
  localparam int SEG_A = 0;
  localparam int SEG_B = 1;
  localparam int SEG_C = 2;
  localparam int SEG_D = 3;
  localparam int SEG_E = 4;
  localparam int SEG_F = 5;
  localparam int SEG_G = 6;

  typedef logic [6:0] seg_t;
  typedef logic [3:0] nibble_t;

  // Active-high {g..a} glyph for one hex nibble (lower-case b and d)
  function automatic seg_t hex_to_seg(input nibble_t n);
    seg_t s;
    case (n)
      4'h0:    s = 7'b0111111;
      4'h1:    s = 7'b0000110;
      4'h2:    s = 7'b1011011;
      4'h3:    s = 7'b1001111;
      4'h4:    s = 7'b1100110;
      4'h5:    s = 7'b1101101;
      4'h6:    s = 7'b1111101;
      4'h7:    s = 7'b0000111;
      4'h8:    s = 7'b1111111;
      4'h9:    s = 7'b1101111;
      4'hA:    s = 7'b1110111;
      4'hB:    s = 7'b1111100;
      4'hC:    s = 7'b0111001;
      4'hD:    s = 7'b1011110;
      4'hE:    s = 7'b1111001;
      default: s = 7'b1110001;
    endcase
    return s;
  endfunction

endpackage
`default_nettype wire

// File: rtl/mfp_hex_to_seven_segment.sv
`default_nettype none
// ============================================================================
//  Module   : mfp_hex_to_seven_segment
//  Purpose  : Combinational nibble to active-high {g..a} segment pattern.
//  Revision : 1.0  initial release
// ============================================================================
module mfp_hex_to_seven_segment
  import mfp_pwm_multi_digit_display_pkg::*;
(
  input  logic [3:0] i_nibble,
  output logic [6:0] o_seg
);

  // Pure table lookup; polarity is applied by the caller
  always_comb begin
    o_seg = hex_to_seg(i_nibble);
  end

endmodule
`default_nettype wire

// File: rtl/mfp_pwm_multi_digit_display.sv
`default_nettype none
// ============================================================================
//  Module   : mfp_pwm_multi_digit_display
//  Purpose  : N-digit multiplexed seven-segment scanner with per-digit
//             enable and dot, leading-zero suppression, PWM brightness,
//             anti-ghost blanking and frame-atomic input capture.
//  Revision : 1.0  initial release
// ============================================================================
module mfp_pwm_multi_digit_display
  import mfp_pwm_multi_digit_display_pkg::*;
#(
  parameter int N_DIGITS         = 8,
  parameter int SCAN_DIV         = 12500,
  parameter int PWM_BITS         = 4,
  parameter int GHOST_BLANK      = 4,
  parameter int ANODE_ACTIVE_LOW = 1,
  parameter int SEG_ACTIVE_LOW   = 1
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic [4*N_DIGITS-1:0]   number,
  input  logic [N_DIGITS-1:0]     dots,
  input  logic [N_DIGITS-1:0]     enable_mask,
  input  logic                    lzs,
  input  logic [PWM_BITS-1:0]     brightness,
  output logic [6:0]              seven_segments,
  output logic                    dot,
  output logic [N_DIGITS-1:0]     anodes,
  output logic                    frame_done
);

  localparam int c_PCNT_W = $clog2(SCAN_DIV);
  localparam int c_DIG_W  = $clog2(N_DIGITS);

  localparam logic [c_PCNT_W-1:0] c_PCNT_MAX = c_PCNT_W'(SCAN_DIV - 1);
  localparam logic [c_PCNT_W-1:0] c_GHOST    = c_PCNT_W'(GHOST_BLANK);
  localparam logic [c_DIG_W-1:0]  c_DIG_MAX  = c_DIG_W'(N_DIGITS - 1);

  // Idle levels of each pin group; XOR with these applies polarity
  localparam logic [N_DIGITS-1:0] c_AN_OFF  = (ANODE_ACTIVE_LOW != 0) ? '1 : '0;
  localparam logic [6:0]          c_SEG_OFF = (SEG_ACTIVE_LOW != 0) ? 7'h7F : 7'h00;
  localparam logic                c_DP_OFF  = (SEG_ACTIVE_LOW != 0);

  // Scan state
  logic [c_PCNT_W-1:0]   r_pcnt;
  logic [c_DIG_W-1:0]    r_digit;
  logic                  r_frame_done;
  logic                  r_load_pending;

  // Frame-atomic shadow copies of the inputs
  logic [4*N_DIGITS-1:0] r_sh_number;
  logic [N_DIGITS-1:0]   r_sh_dots;
  logic [N_DIGITS-1:0]   r_sh_en;
  logic [N_DIGITS-1:0]   r_sh_blank;
  logic [PWM_BITS-1:0]   r_sh_bright;

  // Registered pins
  logic [N_DIGITS-1:0]   r_anodes;
  logic [6:0]            r_segs;
  logic                  r_dot;

  logic                  w_tick;
  logic                  w_frame_end;
  logic                  w_load;
  logic [N_DIGITS-1:0]   w_blank_mask;
  logic [3:0]            w_nibble;
  logic [6:0]            w_seg_hi;
  logic [PWM_BITS-1:0]   w_pwm_cnt;
  logic                  w_pwm_on;
  logic                  w_lit;
  logic                  w_seg_on;
  logic                  w_dot_on;
  logic [N_DIGITS-1:0]   w_onehot;

  assign w_tick      = (r_pcnt == c_PCNT_MAX);
  assign w_frame_end = w_tick && (r_digit == c_DIG_MAX);
  assign w_load      = w_frame_end || r_load_pending;

  // Prescaler and digit counter; digit advances once per slot
  always_ff @(posedge clock) begin
    if (reset) begin
      r_pcnt  <= '0;
      r_digit <= '0;
    end else if (w_tick) begin
      r_pcnt  <= '0;
      r_digit <= (r_digit == c_DIG_MAX) ? '0 : r_digit + 1'b1;
    end else begin
      r_pcnt  <= r_pcnt + 1'b1;
    end
  end

  // One-cycle pulse following the tick that closes the last slot
  always_ff @(posedge clock) begin
    if (reset) begin
      r_frame_done <= 1'b0;
    end else begin
      r_frame_done <= w_frame_end;
    end
  end

  // Leading-zero mask: digit i blanks when it and all higher nibbles are 0
  always_comb begin : lzs_mask
    logic v_upper_zero;
    w_blank_mask = '0;
    v_upper_zero = 1'b1;
    for (int i = N_DIGITS - 1; i >= 1; i--) begin
      v_upper_zero    = v_upper_zero && (number[4*i +: 4] == 4'h0);
      w_blank_mask[i] = lzs && v_upper_zero;
    end
  end

  // Capture inputs only at frame boundaries (or once after reset)
  always_ff @(posedge clock) begin
    if (reset) begin
      r_sh_number    <= '0;
      r_sh_dots      <= '0;
      r_sh_en        <= '0;
      r_sh_blank     <= '0;
      r_sh_bright    <= '0;
      r_load_pending <= 1'b1;
    end else if (w_load) begin
      r_sh_number    <= number;
      r_sh_dots      <= dots;
      r_sh_en        <= enable_mask;
      r_sh_blank     <= w_blank_mask;
      r_sh_bright    <= brightness;
      r_load_pending <= 1'b0;
    end
  end

  assign w_nibble = r_sh_number[{r_digit, 2'b00} +: 4];

  mfp_hex_to_seven_segment u_hex (
    .i_nibble (w_nibble),
    .o_seg    (w_seg_hi)
  );

  // PWM uses the low prescaler bits as a sawtooth; full scale is always on
  assign w_pwm_cnt = r_pcnt[PWM_BITS-1:0];
  assign w_pwm_on  = (r_sh_bright == '1) || (w_pwm_cnt < r_sh_bright);
  assign w_lit     = (r_pcnt >= c_GHOST) && r_sh_en[r_digit] && w_pwm_on;
  assign w_seg_on  = w_lit && !r_sh_blank[r_digit];
  assign w_dot_on  = w_lit && r_sh_dots[r_digit];
  assign w_onehot  = {{(N_DIGITS-1){1'b0}}, 1'b1} << r_digit;

  // Output register: every pin is glitch-free and one cycle behind the scan state
  always_ff @(posedge clock) begin
    if (reset) begin
      r_anodes <= c_AN_OFF;
      r_segs   <= c_SEG_OFF;
      r_dot    <= c_DP_OFF;
    end else begin
      r_anodes <= (w_lit ? w_onehot : '0) ^ c_AN_OFF;
      r_segs   <= (w_seg_on ? w_seg_hi : 7'h00) ^ c_SEG_OFF;
      r_dot    <= w_dot_on ^ c_DP_OFF;
    end
  end

  assign anodes         = r_anodes;
  assign seven_segments = r_segs;
  assign dot            = r_dot;
  assign frame_done     = r_frame_done;

endmodule
`default_nettype wire

// File: tb/tb_mfp_pwm_multi_digit_display.sv
`default_nettype none
// ============================================================================
//  Module   : tb_mfp_pwm_multi_digit_display
//  Purpose  : Scoreboard bench for the multiplexed display scanner.
//             Expected lit runs (anode/segment/dot/length) are queued by the
//             stimulus; a monitor segments the pin stream into runs and pops.
//  Revision : 1.0  initial release
// ============================================================================
module tb_mfp_pwm_multi_digit_display;

  localparam logic [15:0] IDLE = {8'hFF, 7'h7F, 1'b1};

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] number = 32'h0;
  logic [7:0]  dots = 8'h00;
  logic [7:0]  enable_mask = 8'hFF;
  logic        lzs = 1'b0;
  logic [3:0]  brightness = 4'hF;
  logic [6:0]  seven_segments;
  logic        dot;
  logic [7:0]  anodes;
  logic        frame_done;

  mfp_pwm_multi_digit_display #(
    .N_DIGITS(8), .SCAN_DIV(16), .PWM_BITS(4), .GHOST_BLANK(2),
    .ANODE_ACTIVE_LOW(1), .SEG_ACTIVE_LOW(1)
  ) dut (
    .clock(clock), .reset(reset), .number(number), .dots(dots),
    .enable_mask(enable_mask), .lzs(lzs), .brightness(brightness),
    .seven_segments(seven_segments), .dot(dot), .anodes(anodes),
    .frame_done(frame_done)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [7:0] an;
    logic [6:0] seg;
    logic       dp;
    int         len;
    string      tag;
  } exp_t;

  exp_t q[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   n_emit   = 0;
  bit   mon_en   = 1'b0;
  bit   fd_chk_en = 1'b0;

  // Active-high {g..a} glyphs, hand-copied from the encode table
  logic [6:0] lut [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                           7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Queue the runs one frame should produce for the given inputs
  task automatic push_frame(input logic [31:0] num, input logic [7:0] dts,
                            input logic [7:0] msk, input logic lz,
                            input int len, input string tag);
    exp_t e;
    logic [3:0]  nib;
    logic [31:0] upper;
    for (int d = 0; d < 8; d++) begin
      if (msk[d]) begin
        nib   = num[4*d +: 4];
        upper = num >> (4*d);
        e.an  = ~(8'h01 << d);
        e.seg = (lz && d >= 1 && upper == 32'h0) ? 7'h7F : ~lut[nib];
        e.dp  = ~dts[d];
        e.len = len;
        e.tag = $sformatf("%s_d%0d", tag, d);
        q.push_back(e);
      end
    end
  endtask

  task automatic emit(input logic [15:0] v, input int len);
    exp_t e;
    n_emit++;
    if (q.size() == 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL unexpected_run actual an=%h seg=%h dp=%b len=%0d required=none",
               v[15:8], v[7:1], v[0], len);
    end else begin
      e = q.pop_front();
      check({e.tag, "_anodes"}, 32'(v[15:8]), 32'(e.an));
      check({e.tag, "_segs"},   32'(v[7:1]),  32'(e.seg));
      check({e.tag, "_dot"},    32'(v[0]),    32'(e.dp));
      check({e.tag, "_len"},    len,          e.len);
    end
  endtask

  // Run monitor: groups identical non-idle pin vectors into runs
  logic [15:0] prev = IDLE;
  int          run_len = 0;
  always @(negedge clock) begin : run_monitor
    logic [15:0] cur;
    cur = {anodes, seven_segments, dot};
    if (!mon_en) begin
      prev    = IDLE;
      run_len = 0;
    end else begin
      if (anodes != 8'hFF) check("one_anode", $countones(~anodes), 1);
      if (cur == prev && cur != IDLE) begin
        run_len++;
      end else begin
        if (prev != IDLE) emit(prev, run_len);
        prev    = cur;
        run_len = (cur != IDLE) ? 1 : 0;
      end
    end
  end

  // Frame pulse spacing monitor
  int fd_cnt = -1;
  always @(negedge clock) begin : fd_monitor
    if (!fd_chk_en) begin
      fd_cnt = -1;
    end else begin
      if (fd_cnt >= 0) fd_cnt++;
      if (frame_done === 1'b1) begin
        if (fd_cnt >= 0) check("frame_period", fd_cnt, 128);
        fd_cnt = 0;
      end else if (fd_cnt > 200) begin
        check("frame_timeout", fd_cnt, 128);
        fd_cnt = -1;
      end
    end
  end

  task automatic wait_fd();
    int k = 0;
    do begin
      @(negedge clock);
      k++;
    end while (frame_done !== 1'b1 && k < 400);
    if (frame_done !== 1'b1) begin
      n_checks++;
      n_fail++;
      $display("FAIL wait_frame_done actual=timeout required=pulse");
    end
  endtask

  task automatic observe(input int nframes, input string tag);
    int e0;
    wait_fd();
    @(negedge clock);
    #1 mon_en = 1'b1;
    e0 = n_emit;
    repeat (nframes) wait_fd();
    @(negedge clock);
    #1 mon_en = 1'b0;
    check({tag, "_leftover"}, q.size(), 0);
    q.delete();
    if (tag == "p5") check("p5_runs", n_emit - e0, 0);
  endtask

  initial begin : watchdog
    #300000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "timeout");
  end

  initial begin : stimulus
    int k;
    @(posedge clock);
    repeat (5) begin
      @(negedge clock);
      check("rst_anodes", anodes, 8'hFF);
      check("rst_segs", seven_segments, 7'h7F);
      check("rst_dot", dot, 1'b1);
      check("rst_fd", frame_done, 1'b0);
    end
    #1 reset = 1'b0;
    fd_chk_en = 1'b1;

    // Plain hex, full brightness
    number = 32'h000000A5; dots = 8'h00; enable_mask = 8'hFF; lzs = 1'b0; brightness = 4'hF;
    push_frame(number, dots, enable_mask, lzs, 14, "p1");
    observe(1, "p1");

    // Leading-zero suppression
    lzs = 1'b1;
    push_frame(number, dots, enable_mask, lzs, 14, "p2");
    observe(1, "p2");

    // All-zero value keeps digit 0
    number = 32'h0;
    push_frame(number, dots, enable_mask, lzs, 14, "p3");
    observe(1, "p3");

    // Low brightness with dots on outer digits
    number = 32'h000000A5; lzs = 1'b0; brightness = 4'h4; dots = 8'h81;
    push_frame(number, dots, enable_mask, lzs, 2, "p4");
    observe(1, "p4");

    // Zero brightness: nothing lights
    brightness = 4'h0; dots = 8'h00;
    observe(1, "p5");

    // Partial enable mask
    brightness = 4'hF; enable_mask = 8'hF0; number = 32'h12345678;
    push_frame(number, dots, enable_mask, lzs, 14, "p6");
    observe(1, "p6");

    // Mid-frame change appears only after the frame boundary
    enable_mask = 8'hFF; number = 32'h000000A5;
    push_frame(32'h000000A5, 8'h00, 8'hFF, 1'b0, 14, "p7old");
    push_frame(32'h12345678, 8'h00, 8'hFF, 1'b0, 14, "p7new");
    wait_fd();
    @(negedge clock);
    #1 mon_en = 1'b1;
    repeat (52) @(negedge clock);
    #1 number = 32'h12345678;
    wait_fd();
    wait_fd();
    @(negedge clock);
    #1 mon_en = 1'b0;
    check("p7_leftover", q.size(), 0);
    q.delete();

    // Reset in the middle of slot 5
    fd_chk_en = 1'b0;
    wait_fd();
    repeat (5*16 + 6) @(negedge clock);
    check("pre_rst_lit", anodes, 8'hDF);
    #1 reset = 1'b1;
    @(negedge clock);
    check("midrst_anodes", anodes, 8'hFF);
    check("midrst_segs", seven_segments, 7'h7F);
    check("midrst_dot", dot, 1'b1);
    check("midrst_fd", frame_done, 1'b0);
    repeat (2) @(negedge clock);
    #1 begin reset = 1'b0; number = 32'h000000A5; end
    k = 0;
    do begin
      @(negedge clock);
      k++;
    end while (anodes == 8'hFF && k < 10);
    check("rst_release_latency", k, 3);
    check("rst_release_anodes", anodes, 8'hFE);
    check("rst_release_segs", seven_segments, 7'h12);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
